div_unit: RTL
=============

# div_unit

Iterative 32-bit signed/unsigned integer divider in the EX stage of the five-stage MIPS pipeline. It computes quotient and remainder for DIV and DIVU. The HI/LO results go forward through the EX/MEM pipeline register. While a division is in flight, `stall` holds the enables of the upstream pipeline registers low.

## Interface
- `WIDTH`, 32, operand and result width; iteration count equals `WIDTH`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a division; sampled only in IDLE.
- `signed_op`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start`.
- `a`  in  WIDTH  dividend; sampled with `start`.
- `b`  in  WIDTH  divisor; sampled with `start`.
- `cancel`  in  1  exception flush; aborts any operation in flight.
- `stall`  out  1  pipeline freeze request; combinational.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid this cycle.
- `hi`  out  WIDTH  remainder.
- `lo`  out  WIDTH  quotient.

## Operation
- States are IDLE, CALC, FIX and DONE. All state is registered; `rst` overrides every other input.
- IDLE:
  - If `start` is high and `cancel` is low, latch `signed_op`, `a` and `b`, and load operand magnitudes.
  - Magnitudes are |a| and |b| when signed, raw values otherwise. Go to CALC with iteration counter = 0.
- CALC: restoring division, one quotient bit per cycle.
  - Partial remainder is WIDTH+1 bits wide.
  - Each cycle: shift in the next dividend bit, trial-subtract the divisor magnitude, and keep the result if it is non-negative.
  - After WIDTH iterations, go to FIX.
- FIX, applied in this order:
  - If the latched `b` is 0: `lo` = all ones, `hi` = latched `a`, regardless of `signed_op`.
  - Else if signed: negate the quotient when sign(a) ≠ sign(b), and give the remainder the sign of `a`.
  - 0x80000000 / −1 wraps: `lo` = 0x80000000, `hi` = 0.
  - Register `hi`/`lo`, then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- `hi`/`lo` hold their values until the next FIX update.
- `start` while not in IDLE is ignored. The pipeline cannot issue one, because it is stalled.
- `cancel` in any state:
  - Next state is IDLE.
  - `done` is not asserted for the aborted operation.
  - `hi`/`lo` keep their previous values.
  - `cancel` takes priority over `start` in the same cycle.
- `stall` = (IDLE & `start` & ~`cancel`) | ((CALC | FIX) & ~`cancel`). It is low in DONE, so the pipeline advances on the cycle `done` is high.

## Timing
- Reset values: state IDLE, `stall` 0, `done` 0, `hi` 0, `lo` 0, counter 0.
- Start accepted in cycle T: CALC spans T+1..T+WIDTH, FIX is T+WIDTH+1, and DONE is T+WIDTH+2 (T+34 at the default width).
- `stall` is high for T..T+WIDTH+1 and low at T+WIDTH+2.
- Back-to-back operations: the earliest next `start` is in the cycle after DONE, which is IDLE.
- `cancel` at cycle C: IDLE at C+1, and `stall` is low already in C.
- `rst` mid-operation: IDLE and reset values at the next edge, with no `done`.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: in IDLE, `start` with `b` = 0 goes directly to DONE at T+1, with `lo` = all ones and `hi` = `a` registered at that edge. `stall` is high only in cycle T.
  - Undefined: divide-by-zero takes the full WIDTH+2-cycle path and produces the same values via FIX.
  - Non-zero divisors are unaffected in both cases.

## Test plan
- Unsigned 100 / 7, `start` at T -> `done` at T+34 with `lo` = 14, `hi` = 2; `stall` high T..T+33, low at T+34.
- Signed −7 / 2 (0xFFFFFFF9 / 2) -> `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. Signed 7 / −2 -> `lo` = 0xFFFFFFFD, `hi` = 1.
- Signed 0x80000000 / 0xFFFFFFFF -> `lo` = 0x80000000, `hi` = 0. Unsigned same operands -> `lo` = 0, `hi` = 0x80000000.
- 5 / 0, signed and unsigned -> `lo` = 0xFFFFFFFF, `hi` = 5. `done` at T+34 without the macro, T+1 with `DIV_ZERO_FAST_EN`.
- Cancel mid-operation:
  - Previous result `lo` = 14, `hi` = 2.
  - Start 50 / 3, then `cancel` at T+10 -> `stall` low at T+10, IDLE at T+11, no `done`, `hi`/`lo` still 2/14.
  - New `start` at T+12 completes normally at T+46.
- `rst` at T+20 of a division -> all outputs 0 at T+21. A `start` held during reset is ignored; a `start` after reset works normally.

Source files
------------

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the EX-stage control and the
// iterative divider.
//   master (pipeline side): drives start, signed_op, a, b, cancel;
//                           observes stall, done, hi, lo
//   slave  (div_unit)     : the mirror image
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, a, b, cancel,
    input  stall, done, hi, lo
  );

  modport slave (
    input  start, signed_op, a, b, cancel,
    output stall, done, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU in the EX stage.
// It produces one quotient bit per cycle. HI receives the remainder and LO
// receives the quotient.
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   bus (slave)   start/signed_op/a/b/cancel in; stall/done/hi/lo out
//                 stall is combinational; done/hi/lo are registered
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor completes straight
// from IDLE in one cycle instead of walking through CALC/FIX.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;       // latched raw operands for the sign fix-up
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;        // WIDTH+1-bit working remainder
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Two's-complement magnitude. The most negative value maps to itself,
  // and that result is also correct when it is read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Restoring step. shifted[WIDTH] set implies shifted > divisor, so the
  // trial result is then non-negative and fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  // Sign fix-up. 0x80000000 / -1 wraps naturally to 0x80000000 rem 0.
  always_comb begin
    q_fix = quo_q;
    r_fix = rem_q;
    if (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) begin
      q_fix = ~quo_q + WIDTH'(1);
    end
    if (sgn_q && a_q[WIDTH-1]) begin
      r_fix = ~rem_q + WIDTH'(1);
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = bus.a;
          b_d   = bus.b;
          sgn_d = bus.signed_op;
          quo_d = magnitude(bus.a, bus.signed_op);
          dvs_d = magnitude(bus.b, bus.signed_op);
          rem_d = '0;
          cnt_d = '0;
`ifdef DIV_ZERO_FAST_EN
          if (bus.b == '0) begin
            hi_d    = bus.a;
            lo_d    = '1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIX: begin
        if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        done_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush abandons the operation, and the previous results stay visible.
    if (bus.cancel) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Freeze the pipeline from acceptance through FIX. The freeze drops in
  // DONE so the pipeline advances with the result. Reset suppresses it.
  assign bus.stall = !rst && !bus.cancel &&
                     (((state_q == IDLE) && bus.start) ||
                      (state_q == CALC) || (state_q == FIX));

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
